cmd_frame_rx: RTL

//  Parametrised command-frame receiver behind the GTX RX lane; next generation of the fixed-layout command decoder.

---
 rtl/cmd_rx_pkg.sv | 27 ++
 rtl/cmd_rx_csum.sv | 29 ++
 rtl/cmd_frame_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cmd_rx_pkg.sv
// Shared types and constants for the command-frame receiver.
// Holds the FSM state enum, rx_ctrl codes and default header/tail/opcode words.
package cmd_rx_pkg;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_HDR0,
      ST_HDR1,
      ST_OPC,
      ST_PAY,
      ST_CSUM,
      ST_TAIL0,
      ST_TAIL1
   } state_t;

   localparam logic [1:0] RX_CTRL_DATA  = 2'b00;
   localparam logic [1:0] RX_CTRL_COMMA = 2'b01;

   localparam logic [15:0] DEF_HDR0    = 16'h2410;
   localparam logic [15:0] DEF_HDR1    = 16'h1984;
   localparam logic [15:0] DEF_TAIL0   = 16'hDBEF;
   localparam logic [15:0] DEF_TAIL1   = 16'hE67B;
   localparam logic [15:0] DEF_OP_CFG  = 16'h0001;
   localparam logic [15:0] DEF_OP_TIME = 16'h0002;
   localparam logic [15:0] DEF_OP_SHUT = 16'hA5A5;

endpackage

// File: rtl/cmd_rx_csum.sv
// Modulo-2^DW running checksum: clear, accumulate, compare.
// Ports: clk, rst_n, clr, en, din (added word), ref_word (expected sum) -> match.
module cmd_rx_csum #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] din,
   input  logic [DW-1:0] ref_word,
   output logic          match
);

   logic [DW-1:0] acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + din;
      end
   end

   assign match = (acc == ref_word);

endmodule

// File: rtl/cmd_frame_rx.sv
// Command-frame receiver: comma hunt, header/tail match, checksum, commit.
// Ports: clk, rst_n, rx_valid/rx_data/rx_ctrl in; cfg_regs, cfg_opcode,
// cfg_done, shutdown, err_csum, err_op, err_frame out.
// Optional idle timeout mid-frame when CMD_RX_TIMEOUT_EN is defined.
module cmd_frame_rx
   import cmd_rx_pkg::*;
#(
   parameter int            DW      = 16,
   parameter int            NPAY    = 14,
   parameter int            NTIME   = 4,
   parameter logic [DW-1:0] HDR0    = DEF_HDR0,
   parameter logic [DW-1:0] HDR1    = DEF_HDR1,
   parameter logic [DW-1:0] TAIL0   = DEF_TAIL0,
   parameter logic [DW-1:0] TAIL1   = DEF_TAIL1,
   parameter logic [DW-1:0] OP_CFG  = DEF_OP_CFG,
   parameter logic [DW-1:0] OP_TIME = DEF_OP_TIME,
   parameter logic [DW-1:0] OP_SHUT = DEF_OP_SHUT,
   parameter int            TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_valid,
   input  logic [DW-1:0]    rx_data,
   input  logic [1:0]       rx_ctrl,
   output logic [NPAY*DW-1:0] cfg_regs,
   output logic [DW-1:0]    cfg_opcode,
   output logic             cfg_done,
   output logic             shutdown,
   output logic             err_csum,
   output logic             err_op,
   output logic             err_frame
);

   localparam int IW = (NPAY > 1) ? $clog2(NPAY) : 1;

   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic [DW-1:0] opc_q;
   logic [DW-1:0] shadow [NPAY];
   logic [DW-1:0] cfg_q  [NPAY];
   logic          csum_ok, csum_match;
   logic          is_comma, is_data, is_bad, in_frame, tmo;
   logic          csum_clr, csum_en, opc_ld, pay_ld, csum_ld;
   logic          commit, frm_err;

   assign is_comma = (rx_ctrl == RX_CTRL_COMMA);
   assign is_data  = (rx_ctrl == RX_CTRL_DATA);
   assign is_bad   = rx_ctrl[1];
   assign in_frame = (state inside {ST_OPC, ST_PAY, ST_CSUM,
                                    ST_TAIL0, ST_TAIL1});

   cmd_rx_csum #(.DW(DW)) u_csum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (csum_clr),
      .en       (csum_en),
      .din      (rx_data),
      .ref_word (rx_data),
      .match    (csum_match)
   );

`ifdef CMD_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (rx_valid || !in_frame) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // fires on the TIMEOUT-th consecutive idle cycle
   assign tmo = in_frame && !rx_valid &&
                (idle_cnt == TW'(TIMEOUT - 1));
`else
   // no idle limit in this build; term is constant false
   assign tmo = (TIMEOUT < 0);
`endif

   always_comb begin
      state_nxt = state;
      csum_clr  = 1'b0;
      csum_en   = 1'b0;
      opc_ld    = 1'b0;
      pay_ld    = 1'b0;
      csum_ld   = 1'b0;
      commit    = 1'b0;
      frm_err   = 1'b0;
      if (rx_valid && in_frame && (is_bad || is_comma)) begin
         // a comma is also the start of the next frame
         frm_err   = 1'b1;
         state_nxt = is_comma ? ST_HDR0 : ST_HUNT;
      end else if (rx_valid) begin
         unique case (state)
            ST_HUNT: begin
               if (is_comma) state_nxt = ST_HDR0;
            end
            ST_HDR0: begin
               if (is_comma)
                  state_nxt = ST_HDR0;
               else if (is_data && rx_data == HDR0)
                  state_nxt = ST_HDR1;
               else
                  state_nxt = ST_HUNT;
            end
            ST_HDR1: begin
               csum_clr = 1'b1;
               if (is_comma)
                  state_nxt = ST_HDR0;
               else if (is_data && rx_data == HDR1)
                  state_nxt = ST_OPC;
               else
                  state_nxt = ST_HUNT;
            end
            ST_OPC: begin
               csum_en   = 1'b1;
               opc_ld    = 1'b1;
               state_nxt = ST_PAY;
            end
            ST_PAY: begin
               csum_en = 1'b1;
               pay_ld  = 1'b1;
               if (idx == IW'(NPAY - 1)) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
               csum_ld   = 1'b1;
               state_nxt = ST_TAIL0;
            end
            ST_TAIL0: begin
               if (rx_data == TAIL0) begin
                  state_nxt = ST_TAIL1;
               end else begin
                  frm_err   = 1'b1;
                  state_nxt = ST_HUNT;
               end
            end
            ST_TAIL1: begin
               commit    = (rx_data == TAIL1);
               frm_err   = (rx_data != TAIL1);
               state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
         endcase
      end else if (tmo) begin
         frm_err   = 1'b1;
         state_nxt = ST_HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HUNT;
         idx        <= '0;
         opc_q      <= '0;
         csum_ok    <= 1'b0;
         cfg_opcode <= '0;
         cfg_done   <= 1'b0;
         shutdown   <= 1'b0;
         err_csum   <= 1'b0;
         err_op     <= 1'b0;
         err_frame  <= 1'b0;
         for (int k = 0; k < NPAY; k++) begin
            shadow[k] <= '0;
            cfg_q[k]  <= '0;
         end
      end else begin
         state     <= state_nxt;
         cfg_done  <= 1'b0;
         shutdown  <= 1'b0;
         err_csum  <= 1'b0;
         err_op    <= 1'b0;
         err_frame <= frm_err;
         if (opc_ld) begin
            opc_q <= rx_data;
            idx   <= '0;
         end
         if (pay_ld) begin
            shadow[idx] <= rx_data;
            idx         <= idx + 1'b1;
         end
         if (csum_ld) csum_ok <= csum_match;
         if (commit) begin
            if (!csum_ok) begin
               err_csum <= 1'b1;
            end else if (opc_q == OP_CFG) begin
               for (int k = 0; k < NPAY; k++) cfg_q[k] <= shadow[k];
               cfg_opcode <= opc_q;
               cfg_done   <= 1'b1;
            end else if (opc_q == OP_TIME) begin
               for (int k = 0; k < NTIME; k++) cfg_q[k] <= shadow[k];
               cfg_opcode <= opc_q;
               cfg_done   <= 1'b1;
            end else if (opc_q == OP_SHUT) begin
               cfg_opcode <= opc_q;
               shutdown   <= 1'b1;
            end else begin
               err_op <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NPAY; g++) begin : g_flat
      assign cfg_regs[g*DW +: DW] = cfg_q[g];
   end

endmodule
